// File: rtl/ps2_frame_tx.sv
// ps2_frame_tx: PS/2 device-to-host frame transmitter fed by a scan-code FIFO.
// Each byte is sent as start(0), 8 data bits LSB first, odd parity, stop(1).
// Optional feature macro: PS2_FRAME_TX_PARITY_ERR_INJECT_EN adds input
// inject_parity_err, which inverts the parity bit of the frame popped with it.
module ps2_frame_tx #(
  parameter int unsigned HALF_PERIOD_CYCLES = 2000,
  parameter int unsigned GAP_CYCLES         = 32000,
  parameter int unsigned FIFO_DEPTH         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       inhibit,
`ifdef PS2_FRAME_TX_PARITY_ERR_INJECT_EN
  input  logic       inject_parity_err,
`endif
  output logic       ps2_clk_o,
  output logic       ps2_data_o,
  output logic       busy,
  output logic       frame_done_strb,
  output logic       abort_strb
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W     = PTR_W + 1;
  localparam int unsigned CNT_MAX   = (HALF_PERIOD_CYCLES > GAP_CYCLES) ? HALF_PERIOD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned HALF_LAST = HALF_PERIOD_CYCLES - 1;
  localparam int unsigned GAP_LAST  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [3:0]  LAST_IDX  = 4'd10;
  localparam logic [3:0]  PAR_IDX   = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIT_HIGH,
    S_BIT_LOW,
    S_GAP,
    S_HOLD
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]         r_idx, w_idx_nxt;
  logic               r_retx, w_retx_nxt;
  logic [7:0]         r_byte;
  logic               r_par;
  logic               w_start, w_pop, w_push;
  logic               w_done_evt, w_abort_evt;
  logic               r_done_evt, r_abort_evt;
  logic               w_half_end, w_gap_end, w_abortable;
  logic               w_frame_bit, w_inj;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0]   r_count, w_count_nxt;
  logic               w_fifo_nempty;

  logic               r_tx_ready, r_ps2_clk, r_ps2_data, r_busy;
  logic               r_frame_done, r_abort;

`ifdef PS2_FRAME_TX_PARITY_ERR_INJECT_EN
  assign w_inj = inject_parity_err;
`else
  assign w_inj = 1'b0;
`endif

  assign w_push        = tx_valid && r_tx_ready;
  assign w_fifo_nempty = (r_count != '0);
  assign w_half_end    = (r_cnt == CNT_W'(HALF_LAST));
  assign w_gap_end     = (r_cnt == CNT_W'(GAP_LAST));
  assign w_abortable   = inhibit && (r_idx <= PAR_IDX);
  assign w_pop         = w_start && !r_retx;

  // FIFO occupancy next value
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + OCC_W'(1);
      2'b01:   w_count_nxt = r_count - OCC_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO pointers, occupancy and ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tx_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count    <= w_count_nxt;
      r_tx_ready <= (w_count_nxt != OCC_W'(FIFO_DEPTH));
    end
  end

  // FIFO storage (no reset needed, gated by occupancy)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_data;
  end

  // Frame byte and parity; both survive an abort for the retransmit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte <= '0;
      r_par  <= 1'b0;
    end else if (w_pop) begin
      r_byte <= r_mem[r_rd_ptr];
      r_par  <= (~^r_mem[r_rd_ptr]) ^ w_inj;
    end
  end

  // Select the frame bit addressed by the bit index
  always_comb begin
    w_frame_bit = 1'b1;
    if (r_idx == 4'd0)       w_frame_bit = 1'b0;
    else if (r_idx <= 4'd8)  w_frame_bit = r_byte[3'(r_idx - 4'd1)];
    else if (r_idx == PAR_IDX) w_frame_bit = r_par;
  end

  // FSM state, phase counter, bit index and retransmit flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_retx  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_retx  <= w_retx_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_retx_nxt  = r_retx;
    w_start     = 1'b0;
    w_done_evt  = 1'b0;
    w_abort_evt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!inhibit && (r_retx || w_fifo_nempty)) begin
          w_start     = 1'b1;
          w_retx_nxt  = 1'b0;
          w_idx_nxt   = '0;
          w_state_nxt = S_BIT_HIGH;
        end
      end
      S_BIT_HIGH: begin
        if (w_abortable) begin
          w_abort_evt = 1'b1;
          w_retx_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_HOLD;
        end else if (w_half_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_BIT_LOW;
        end
      end
      S_BIT_LOW: begin
        if (w_abortable) begin
          w_abort_evt = 1'b1;
          w_retx_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_HOLD;
        end else if (w_half_end) begin
          w_cnt_nxt = '0;
          if (r_idx < LAST_IDX) begin
            w_idx_nxt   = r_idx + 4'd1;
            w_state_nxt = S_BIT_HIGH;
          end else begin
            w_done_evt  = 1'b1;
            w_state_nxt = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (w_gap_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        w_cnt_nxt = '0;
        if (!inhibit) w_state_nxt = S_GAP;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the current state; strobes delayed to line up
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ps2_clk    <= 1'b1;
      r_ps2_data   <= 1'b1;
      r_busy       <= 1'b0;
      r_done_evt   <= 1'b0;
      r_abort_evt  <= 1'b0;
      r_frame_done <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_ps2_clk    <= (r_state != S_BIT_LOW);
      r_ps2_data   <= ((r_state == S_BIT_HIGH) || (r_state == S_BIT_LOW)) ? w_frame_bit : 1'b1;
      r_busy       <= (r_state != S_IDLE);
      r_done_evt   <= w_done_evt;
      r_abort_evt  <= w_abort_evt;
      r_frame_done <= r_done_evt;
      r_abort      <= r_abort_evt;
    end
  end

  assign tx_ready        = r_tx_ready;
  assign ps2_clk_o       = r_ps2_clk;
  assign ps2_data_o      = r_ps2_data;
  assign busy            = r_busy;
  assign frame_done_strb = r_frame_done;
  assign abort_strb      = r_abort;

endmodule

// File: tb/tb_ps2_frame_tx.sv
// tb_ps2_frame_tx: directed bench for ps2_frame_tx with short bit/gap timing.
`timescale 1ns/1ps
module tb_ps2_frame_tx;

  localparam int unsigned HALF  = 3;
  localparam int unsigned GAP   = 5;
  localparam int unsigned DEPTH = 4;
  localparam int FRAME_LEN = 22 * HALF;
  localparam int SPACING   = FRAME_LEN + GAP + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       inhibit;
  logic       ps2_clk_o;
  logic       ps2_data_o;
  logic       busy;
  logic       frame_done_strb;
  logic       abort_strb;
`ifdef PS2_FRAME_TX_PARITY_ERR_INJECT_EN
  logic       inject_parity_err;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_abort = 0;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  ps2_frame_tx #(
    .HALF_PERIOD_CYCLES(HALF),
    .GAP_CYCLES(GAP),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .inhibit(inhibit),
`ifdef PS2_FRAME_TX_PARITY_ERR_INJECT_EN
    .inject_parity_err(inject_parity_err),
`endif
    .ps2_clk_o(ps2_clk_o),
    .ps2_data_o(ps2_data_o),
    .busy(busy),
    .frame_done_strb(frame_done_strb),
    .abort_strb(abort_strb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;
  always @(posedge clk) if (abort_strb === 1'b1) n_abort++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Data must not move while the PS/2 clock stays low
  logic prev_clk, prev_data;
  always @(negedge clk) begin
    if (prev_clk === 1'b0 && ps2_clk_o === 1'b0) chk("data_stable", 32'(ps2_data_o), 32'(prev_data));
    prev_clk  = ps2_clk_o;
    prev_data = ps2_data_o;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic wait_start(output int ts);
    int n;
    n = 0;
    while (ps2_data_o !== 1'b0 && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) chk("start_timeout", 32'(n), 32'(0));
    ts = cyc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 500) begin
      step();
      n++;
    end
    chk("idle_reached", 32'(busy), 32'(0));
  endtask

  // Capture one frame: data sampled at each clock fall, timing checked
  task automatic capture(output logic [10:0] f, output int ts);
    int n;
    f = '1;
    wait_start(ts);
    for (int b = 0; b < 11; b++) begin
      n = 0;
      while (ps2_clk_o !== 1'b0 && n < 100) begin step(); n++; end
      if (b == 0) chk("first_fall", 32'(cyc - ts), 32'(HALF));
      f[b] = ps2_data_o;
      n = 0;
      while (ps2_clk_o !== 1'b1 && n < 100) begin step(); n++; end
    end
    chk("frame_len", 32'(cyc - ts), 32'(FRAME_LEN));
    chk("done_strb", 32'(frame_done_strb), 32'(1));
  endtask

  task automatic quiet(input string name, input int ncyc);
    int starts;
    starts = 0;
    for (int i = 0; i < ncyc; i++) begin
      step();
      if (ps2_data_o === 1'b0) starts++;
    end
    chk(name, 32'(starts), 32'(0));
    chk({name, "_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    vec_t        vecs[6];
    logic [10:0] f;
    logic [10:0] burst_exp[4];
    logic [7:0]  ovf_data[6];
    logic [10:0] ovf_exp[4];
    int          ts, ts_arr[4], r;
    int          n;

    vecs[0] = '{8'h00, 11'h600};
    vecs[1] = '{8'hFF, 11'h7FE};
    vecs[2] = '{8'h01, 11'h402};
    vecs[3] = '{8'h80, 11'h500};
    vecs[4] = '{8'h5A, 11'h6B4};
    vecs[5] = '{8'hF0, 11'h7E0};
    burst_exp[0] = 11'h438; burst_exp[1] = 11'h452;
    burst_exp[2] = 11'h464; burst_exp[3] = 11'h7E0;
    ovf_data[0] = 8'h11; ovf_data[1] = 8'h22; ovf_data[2] = 8'h33;
    ovf_data[3] = 8'h44; ovf_data[4] = 8'h55; ovf_data[5] = 8'h66;
    ovf_exp[0] = 11'h622; ovf_exp[1] = 11'h644;
    ovf_exp[2] = 11'h666; ovf_exp[3] = 11'h688;

    rst = 1'b1; tx_data = '0; tx_valid = 1'b0; inhibit = 1'b0;
`ifdef PS2_FRAME_TX_PARITY_ERR_INJECT_EN
    inject_parity_err = 1'b0;
`endif
    repeat (3) step();
    chk("rst_clk", 32'(ps2_clk_o), 32'(1));
    chk("rst_data", 32'(ps2_data_o), 32'(1));
    chk("rst_ready", 32'(tx_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(frame_done_strb), 32'(0));
    chk("rst_abort", 32'(abort_strb), 32'(0));
    rst = 1'b0;
    repeat (3) step();

    // Push latency and the 0x1C frame
    push(8'h1C);
    chk("lat_n_busy", 32'(busy), 32'(0));
    step();
    chk("lat_n1_data", 32'(ps2_data_o), 32'(1));
    step();
    chk("lat_n2_data", 32'(ps2_data_o), 32'(0));
    chk("lat_n2_busy", 32'(busy), 32'(1));
    capture(f, ts);
    chk("frame_1c", 32'(f), 32'h438);
    step();
    chk("done_one_cycle", 32'(frame_done_strb), 32'(0));

    // Table of single bytes
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].data);
      capture(f, ts);
      chk($sformatf("vec%0d_frame", i), 32'(f), 32'(vecs[i].frame));
    end
    wait_idle();

    // Back-to-back burst filling the FIFO while the host inhibits
    inhibit = 1'b1;
    push(8'h1C); push(8'h29); push(8'h32);
    chk("burst_ready_3", 32'(tx_ready), 32'(1));
    push(8'hF0);
    chk("burst_ready_4", 32'(tx_ready), 32'(0));
    inhibit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      capture(f, ts_arr[i]);
      chk($sformatf("burst%0d_frame", i), 32'(f), 32'(burst_exp[i]));
      if (i > 0) chk($sformatf("burst%0d_spacing", i), 32'(ts_arr[i] - ts_arr[i-1]), 32'(SPACING));
    end
    wait_idle();

    // Overflow: valid held for 6 bytes, only 4 fit
    inhibit  = 1'b1;
    tx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tx_data = ovf_data[i];
      step();
    end
    tx_valid = 1'b0;
    chk("ovf_ready", 32'(tx_ready), 32'(0));
    inhibit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      capture(f, ts);
      chk($sformatf("ovf%0d_frame", i), 32'(f), 32'(ovf_exp[i]));
    end
    wait_idle();
    quiet("ovf_no_extra", 120);
    chk("ovf_ready_after", 32'(tx_ready), 32'(1));

    // Inhibit during bit 5 of 0x21: abort, hold, retransmit
    push(8'h21);
    wait_start(ts);
    repeat (10 * HALF + 1) step();
    inhibit = 1'b1;
    n = 0;
    while (abort_strb !== 1'b1 && n < 6) begin step(); n++; end
    chk("abort_seen", 32'(abort_strb), 32'(1));
    chk("abort_clk", 32'(ps2_clk_o), 32'(1));
    chk("abort_data", 32'(ps2_data_o), 32'(1));
    step();
    chk("abort_one_cycle", 32'(abort_strb), 32'(0));
    repeat (10) step();
    chk("hold_busy", 32'(busy), 32'(1));
    chk("hold_clk", 32'(ps2_clk_o), 32'(1));
    inhibit = 1'b0;
    r = cyc;
    capture(f, ts);
    chk("retx_frame", 32'(f), 32'h642);
    chk("retx_delay", 32'(ts - r), 32'(GAP + 3));
    chk("abort_count", 32'(n_abort), 32'(1));
    wait_idle();
    quiet("retx_no_extra", 100);

    // Inhibit at bit 10 is ignored
    push(8'h29);
    fork
      capture(f, ts);
      begin
        int ts2;
        wait_start(ts2);
        repeat (20 * HALF + 1) step();
        inhibit = 1'b1;
      end
    join
    chk("bit10_frame", 32'(f), 32'h452);
    repeat (3) step();
    chk("bit10_no_abort", 32'(n_abort), 32'(1));
    inhibit = 1'b0;
    wait_idle();

    // Reset during bit 4 with two bytes still queued
    inhibit = 1'b1;
    push(8'h1C); push(8'h29); push(8'h32);
    inhibit = 1'b0;
    wait_start(ts);
    repeat (8 * HALF + 1) step();
    rst = 1'b1;
    step();
    chk("mrst_clk", 32'(ps2_clk_o), 32'(1));
    chk("mrst_data", 32'(ps2_data_o), 32'(1));
    chk("mrst_ready", 32'(tx_ready), 32'(1));
    chk("mrst_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    quiet("mrst_nothing_sent", 200);

`ifdef PS2_FRAME_TX_PARITY_ERR_INJECT_EN
    // Parity injection on 0x5A flips the parity bit to 0
    inject_parity_err = 1'b1;
    push(8'h5A);
    step();
    inject_parity_err = 1'b0;
    capture(f, ts);
    chk("inject_frame", 32'(f), 32'h4B4);
    wait_idle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_frame_tx.md
# ps2_frame_tx

Parametrised PS/2 device-side frame transmitter. It accepts scan codes over a valid/ready interface, buffers them in a FIFO, and serialises each one as an 11-bit PS/2 device-to-host frame: start bit, 8 data bits LSB first, odd parity, stop bit. It drives `ps2_clk_o` and `ps2_data_o` into `ps2_data_input` for on-chip self-test, replacing hand-timed bench stimulus. Supported behaviour includes configurable bit rate, configurable inter-frame gap, host-inhibit abort/retransmit, and optional parity-error injection.

## Interface
Parameters:
- `HALF_PERIOD_CYCLES`, default 2000: `clk` cycles per PS/2 clock phase (2000 at 50 MHz gives 12.5 kHz). Minimum 2.
- `GAP_CYCLES`, default 32000: idle cycles after each frame's stop bit.
- `FIFO_DEPTH`, default 4: scan-code FIFO entries. Must be a power of 2, ≥2.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `tx_data`  in  8  scan code to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO not full. A push occurs when `tx_valid && tx_ready`.
- `inhibit`  in  1  host inhibit (host holding the clock low).
- `ps2_clk_o`  out  1  PS/2 clock. Idle level is 1.
- `ps2_data_o`  out  1  PS/2 data. Idle level is 1.
- `busy`  out  1  FSM is not in IDLE.
- `frame_done_strb`  out  1  1-cycle pulse on completion of each frame.
- `abort_strb`  out  1  1-cycle pulse when a frame is aborted by `inhibit`.

## Operation
States: IDLE, BIT_HIGH, BIT_LOW, GAP, HOLD.

- **IDLE**
  - `ps2_clk_o` = 1, `ps2_data_o` = 1.
  - If the FIFO is non-empty and `inhibit` = 0: pop into the shift register, compute odd parity, set bit index to 0, go to BIT_HIGH.
- **BIT_HIGH**
  - `ps2_data_o` = frame bit[index]. Bit 0 = 0; bits 1–8 = data; bit 9 = parity (`~^data`); bit 10 = 1.
  - `ps2_clk_o` = 1.
  - Lasts `HALF_PERIOD_CYCLES` cycles, then go to BIT_LOW.
- **BIT_LOW**
  - `ps2_clk_o` = 0, data held.
  - Lasts `HALF_PERIOD_CYCLES` cycles.
  - Then, if index < 10: increment index and go to BIT_HIGH. Otherwise: pulse `frame_done_strb` and go to GAP.
- **GAP**
  - Both lines = 1.
  - Lasts `GAP_CYCLES` cycles, then go to IDLE.
- **Inhibit abort**
  - Trigger: `inhibit` = 1 sampled in BIT_HIGH or BIT_LOW with index ≤ 9.
  - Next cycle: both lines = 1, `abort_strb` pulses, the shift register is retained, go to HOLD.
  - `inhibit` at index 10 is ignored; the frame completes.
- **HOLD**
  - Waits for `inhibit` = 0, then runs a full GAP and retransmits the retained byte before popping the FIFO.
  - A separate retransmit flag selects between the retained byte and a FIFO pop.
- **FIFO**
  - Circular buffer with `$clog2(FIFO_DEPTH)`-bit pointers that wrap naturally, plus an occupancy count of width `$clog2(FIFO_DEPTH)+1`.
  - Push and pop in the same cycle: occupancy unchanged, both pointers advance.
  - Push while full is impossible (`tx_ready` = 0). Pop while empty never occurs.
- **Reset**
  - `rst` = 1 at any time, including mid-frame: on the next edge the state is IDLE, the FIFO is emptied, the retransmit flag is cleared and all counters are 0.
  - Output reset values: `ps2_clk_o` = 1, `ps2_data_o` = 1, `tx_ready` = 1, `busy` = 0, `frame_done_strb` = 0, `abort_strb` = 0.

## Timing
- All outputs are registered.
- **Push latency:** push at edge N into an empty FIFO while in IDLE gives `ps2_data_o` = 0 (start bit) and `busy` = 1 at edge N+2.
- **First clock fall:** `HALF_PERIOD_CYCLES` cycles after the start bit appears.
- **Frame length:** 22·`HALF_PERIOD_CYCLES` cycles from the start bit to the final `ps2_clk_o` rise.
- **`frame_done_strb`:** pulses in the same cycle as the final `ps2_clk_o` rise.
- **Frame-to-frame spacing:** the next start bit appears `GAP_CYCLES`+1 cycles after the final rise (one IDLE cycle).
- **Data stability:** `ps2_data_o` changes only at a BIT_HIGH entry, never while `ps2_clk_o` = 0.
- **`tx_ready`:** follows the registered occupancy; it deasserts the cycle after the push that fills the FIFO.

## Configuration
- Macro: `PS2_FRAME_TX_PARITY_ERR_INJECT_EN`.
- **Defined:** adds input `inject_parity_err` (1 bit).
  - Sampled at the IDLE pop. If 1, that frame's parity bit is inverted.
  - The flag is stored with the frame and is reused on retransmit.
- **Undefined:** the port is absent and parity is always correct.

## Test plan
- **Single byte:** push 0x1C with default parameters → data bits 0,0,0,1,1,1,0,0,0,0,1 at 11 successive clock falls; `frame_done_strb` after 44000 cycles; `ps2_data_input` strobes 0x1C.
- **Back-to-back burst:** push 0x1C, 0x29, 0x32, 0xF0 in consecutive cycles with `FIFO_DEPTH`=4 → `tx_ready` drops after the 4th push; four frames are sent in order with a start-to-start spacing of 44000+32000+1 cycles.
- **Overflow and wrap:** push 6 bytes against `FIFO_DEPTH`=4 while `tx_valid` is held → exactly the accepted bytes are sent in order, pointers wrap, and no byte is lost or duplicated.
- **Inhibit abort:** assert `inhibit` at bit 5 of 0x21 → `abort_strb` pulses and both lines go high; after release plus a gap, 0x21 is retransmitted in full. `inhibit` at bit 10 → the frame completes with no abort.
- **Reset mid-frame:** `rst` during bit 4 with 2 bytes queued → lines are high next edge, `tx_ready` = 1, and nothing is sent afterwards.
- **Parity injection (macro defined):** push 0x5A with `inject_parity_err` = 1 → the parity bit is 0 instead of 1, and the receiver flags or drops the frame.
